// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data_memory between the CPU load/store port and a
// DMA/loader port. The CPU normally wins. After MAX_WAIT consecutive cycles in
// which the DMA asked and lost, the DMA gets priority for exactly one cycle.
// Grants are combinational, so an access completes in its grant cycle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/we/addr/wd/size   CPU access request; cpu_rd read data, cpu_stall hold
//   dma_req/we/addr/wd/size   DMA access request; dma_rd read data, dma_ack done
//   mem_we/addr/wd/size       to data_memory; mem_rd combinational read data back
//   stall_cnt                 saturating count of cycles with cpu_stall=1
module dmem_arbiter #(
    parameter int MAX_WAIT    = 4,
    parameter int WAIT_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wd,
    input  logic [1:0]             cpu_size,
    output logic [31:0]            cpu_rd,
    output logic                   cpu_stall,
    input  logic                   dma_req,
    input  logic                   dma_we,
    input  logic [31:0]            dma_addr,
    input  logic [31:0]            dma_wd,
    input  logic [1:0]             dma_size,
    output logic [31:0]            dma_rd,
    output logic                   dma_ack,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wd,
    output logic [1:0]             mem_size,
    input  logic [31:0]            mem_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        CPU_PRI  = 1'b0,
        DMA_TURN = 1'b1
    } arb_state_t;

    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0]      WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]      WAIT_ONE  = WAIT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_ZERO = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};

    arb_state_t              state_r;
    arb_state_t              state_next_s;
    logic [WAIT_W-1:0]       wait_cnt_r;
    logic [WAIT_W-1:0]       wait_cnt_next_s;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic                    cpu_grant_s;
    logic                    dma_grant_s;
    logic                    dma_lose_s;
    logic                    cpu_stall_s;

    // Grant decision: CPU first, except for the single forced DMA turn.
    always_comb begin
        cpu_grant_s = 1'b0;
        dma_grant_s = 1'b0;
        if (rst) begin
            cpu_grant_s = 1'b0;
            dma_grant_s = 1'b0;
        end else begin
            case (state_r)
                CPU_PRI: begin
                    cpu_grant_s = cpu_req;
                    dma_grant_s = dma_req & ~cpu_req;
                end
                DMA_TURN: begin
                    dma_grant_s = dma_req;
                    cpu_grant_s = cpu_req & ~dma_req;
                end
                default: begin
                    cpu_grant_s = 1'b0;
                    dma_grant_s = 1'b0;
                end
            endcase
        end
    end

    // Reset is folded in so a CPU request during reset is not reported as stalled.
    assign cpu_stall_s = cpu_req & ~cpu_grant_s & ~rst;
    assign dma_lose_s  = dma_req & ~dma_grant_s;

    // Memory-side mux; everything is driven to zero while reset is held.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0000;
        mem_wd   = 32'h0000_0000;
        mem_size = 2'b00;
        if (rst) begin
            mem_we   = 1'b0;
            mem_addr = 32'h0000_0000;
        end else if (dma_grant_s) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_wd   = dma_wd;
            mem_size = dma_size;
        end else begin
            mem_we   = cpu_grant_s & cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
            mem_size = cpu_size;
        end
    end

    // Starvation tracking: count consecutive lost DMA cycles, hand over one turn.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            CPU_PRI: begin
                if (dma_lose_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_next_s    = DMA_TURN;
                        wait_cnt_next_s = WAIT_ZERO;
                    end else begin
                        wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
                    end
                end else begin
                    wait_cnt_next_s = WAIT_ZERO;
                end
            end
            DMA_TURN: begin
                // The turn lasts one cycle whether the DMA used it or withdrew.
                state_next_s    = CPU_PRI;
                wait_cnt_next_s = WAIT_ZERO;
            end
            default: begin
                state_next_s    = CPU_PRI;
                wait_cnt_next_s = WAIT_ZERO;
            end
        endcase
    end

    // State, wait counter and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= CPU_PRI;
            wait_cnt_r  <= WAIT_ZERO;
            stall_cnt_r <= STALL_ZERO;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (cpu_stall_s && (stall_cnt_r != STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign cpu_rd    = mem_rd;
    assign dma_rd    = mem_rd;
    assign cpu_stall = cpu_stall_s;
    assign dma_ack   = dma_grant_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, hand-written corner
// sequences, a saturation instance (MAX_WAIT=1, STALL_CNT_W=4), and random
// protocol-legal traffic compared against a behavioural model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, cpu_rd, dma_rd;
    logic [1:0]  cpu_size, dma_size, mem_size;
    logic        cpu_stall, dma_ack, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [15:0] stall_cnt;

    // saturation instance
    logic        rst2, c2_req, d2_req, c2_stall, d2_ack, m2_we;
    logic        c2_we, d2_we;
    logic [31:0] c2_addr, c2_wd, d2_addr, d2_wd, c2_rd, d2_rd, m2_addr, m2_wd, m2_rd;
    logic [1:0]  c2_size, d2_size, m2_size;
    logic [3:0]  stall_cnt2;

    dmem_arbiter #(.MAX_WAIT(MW), .WAIT_W(8), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_size(cpu_size), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_size(dma_size), .dma_rd(dma_rd), .dma_ack(dma_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size),
        .mem_rd(mem_rd), .stall_cnt(stall_cnt)
    );

    dmem_arbiter #(.MAX_WAIT(1), .WAIT_W(8), .STALL_CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2),
        .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr), .cpu_wd(c2_wd),
        .cpu_size(c2_size), .cpu_rd(c2_rd), .cpu_stall(c2_stall),
        .dma_req(d2_req), .dma_we(d2_we), .dma_addr(d2_addr), .dma_wd(d2_wd),
        .dma_size(d2_size), .dma_rd(d2_rd), .dma_ack(d2_ack),
        .mem_we(m2_we), .mem_addr(m2_addr), .mem_wd(m2_wd), .mem_size(m2_size),
        .mem_rd(m2_rd), .stall_cnt(stall_cnt2)
    );

    // behavioural data_memory (word granularity, 256 words)
    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_addr[9:2]];
    assign m2_rd  = 32'h0000_0000;
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_streak = 0;
    bit          m_turn   = 1'b0;
    int          m_stalls = 0;
    logic [31:0] ref_mem [0:255];
    bit          e_ack, e_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit creq, input bit cwe, input logic [31:0] caddr,
                          input logic [31:0] cwd, input bit dreq, input bit dwe,
                          input logic [31:0] daddr, input logic [31:0] dwd);
        rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wd = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wd = dwd;
    endtask

    // Compare every DUT output against the model for the current cycle, then
    // advance the model past the coming clock edge.
    task automatic step_model();
        bit dw, cw, ewe;
        logic [31:0] ea, ewd;
        logic [1:0]  es;
        dw = 1'b0; cw = 1'b0; ewe = 1'b0; ea = 32'h0; ewd = 32'h0; es = 2'b00;
        if (!rst) begin
            dw = dma_req && (m_turn || !cpu_req);
            cw = cpu_req && !dw;
            if (dw) begin
                ea = dma_addr; ewd = dma_wd; es = dma_size; ewe = dma_we;
            end else begin
                ea = cpu_addr; ewd = cpu_wd; es = cpu_size; ewe = cw && cpu_we;
            end
        end
        e_ack   = dw;
        e_stall = !rst && cpu_req && !cw;
        check("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
        check("dma_ack",   {31'b0, dma_ack},   {31'b0, e_ack});
        check("mem_we",    {31'b0, mem_we},    {31'b0, ewe});
        check("mem_addr",  mem_addr, ea);
        check("mem_wd",    mem_wd, ewd);
        check("mem_size",  {30'b0, mem_size}, {30'b0, es});
        if (!rst) check("stall_cnt", {16'b0, stall_cnt}, m_stalls[31:0]);
        if (cw && !ewe) check("cpu_rd", cpu_rd, ref_mem[ea[9:2]]);
        if (dw && !ewe) check("dma_rd", dma_rd, ref_mem[ea[9:2]]);
        if (rst) begin
            m_streak = 0; m_turn = 1'b0; m_stalls = 0;
        end else begin
            if (m_turn) begin
                m_turn = 1'b0; m_streak = 0;
            end else if (dma_req && !dw) begin
                m_streak++;
                if (m_streak == MW) begin m_turn = 1'b1; m_streak = 0; end
            end else begin
                m_streak = 0;
            end
            if (e_stall && m_stalls < 65535) m_stalls++;
            if (ewe) ref_mem[ea[9:2]] = ewd;
        end
    endtask

    task automatic mid();
        #3;
        step_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit creq; bit cwe; bit dreq;
        bit e_stall; bit e_ack; bit e_we; int e_cnt;
    } vec_t;
    vec_t tbl [22];

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        cpu_size = 2'b10; dma_size = 2'b01;
        rst2 = 1'b1; c2_req = 1'b0; d2_req = 1'b0; c2_we = 1'b0; d2_we = 1'b0;
        c2_addr = 32'h0; c2_wd = 32'h0; d2_addr = 32'h0; d2_wd = 32'h0;
        c2_size = 2'b00; d2_size = 2'b00;
        set_in(1'b1, 1'b1, 1'b1, 32'h100, 32'h1234, 1'b1, 1'b1, 32'h200, 32'h5678);
        #1;

        // reset holds every memory-side output at zero even with requests present
        mid();
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_ack",   {31'b0, dma_ack},   32'h0);
        check("rst_addr",  mem_addr, 32'h0);
        adv();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        mid(); adv();

        // CPU alone: stores then loads return stored data
        set_in(1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0); mid(); adv();
        set_in(1'b0, 1'b1, 1'b1, 32'h14, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0); mid(); adv();
        set_in(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
        check("t1_lw10", cpu_rd, 32'h1111_1111);
        check("t1_we", {31'b0, mem_we}, 32'h0);
        adv();
        set_in(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
        check("t1_lw14", cpu_rd, 32'h2222_2222);
        adv();
        set_in(1'b0, 1'b1, 1'b1, 32'h10, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 32'h0); mid();
        check("t1_sw_we", {31'b0, mem_we}, 32'h1);
        adv();

        // DMA alone: write is acked in the same cycle, CPU later reads it
        dma_size = 2'b10;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF); mid();
        check("t2_ack", {31'b0, dma_ack}, 32'h1);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid(); adv();
        set_in(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
        check("t2_lw40", cpu_rd, 32'hDEAD_BEEF);
        adv();
        dma_size = 2'b01;

        // contention table from a fresh reset: forced turns, and a withdrawn turn
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        for (int i = 11; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        for (int i = 16; i < 20; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid(); adv();
        for (int i = 0; i < 22; i++) begin
            set_in(1'b0, tbl[i].creq, tbl[i].cwe, 32'h100, 32'hC000_0000 + i,
                   tbl[i].dreq, 1'b1, 32'h200, 32'hD000_0000 + i);
            #3;
            check($sformatf("tbl%0d_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].e_stall});
            check($sformatf("tbl%0d_ack", i),   {31'b0, dma_ack},   {31'b0, tbl[i].e_ack});
            check($sformatf("tbl%0d_we", i),    {31'b0, mem_we},    {31'b0, tbl[i].e_we});
            check($sformatf("tbl%0d_cnt", i),   {16'b0, stall_cnt}, tbl[i].e_cnt[31:0]);
            step_model();
            adv();
        end

        // reset during the forced DMA turn drops the turn and clears counters
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h200, 32'h5555); mid(); adv();
        end
        set_in(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h200, 32'h5555); mid();
        check("t4_ack", {31'b0, dma_ack}, 32'h0);
        check("t4_we",  {31'b0, mem_we},  32'h0);
        adv();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h200, 32'h5555);
            #3;
            check($sformatf("t4_post%0d_ack", i), {31'b0, dma_ack}, (i == 4) ? 32'h1 : 32'h0);
            if (i == 0) check("t4_cnt", {16'b0, stall_cnt}, 32'h0);
            step_model();
            adv();
        end

        // randomized protocol-legal traffic against the model
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); mid(); adv();
        e_ack = 1'b0; e_stall = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!e_stall) begin
                cpu_req  = ($urandom_range(0, 3) != 0);
                cpu_we   = $urandom_range(0, 1) == 1;
                cpu_addr = $urandom & 32'h0000_03FC;
                cpu_wd   = $urandom;
                cpu_size = 2'($urandom_range(0, 3));
            end
            if (!dma_req || e_ack) begin
                dma_req  = ($urandom_range(0, 1) == 1);
                dma_we   = $urandom_range(0, 1) == 1;
                dma_addr = $urandom & 32'h0000_03FC;
                dma_wd   = $urandom;
                dma_size = 2'($urandom_range(0, 3));
            end
            mid();
            adv();
        end

        // saturation: MAX_WAIT=1 alternates CPU/DMA, 4-bit counter stops at 15
        rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        rst2 = 1'b1; adv();
        rst2 = 1'b0; c2_req = 1'b1; d2_req = 1'b1;
        for (int i = 0; i < 42; i++) begin
            #3;
            if (i == 0) check("t6_ack0", {31'b0, d2_ack}, 32'h0);
            if (i == 1) check("t6_ack1", {31'b0, d2_ack}, 32'h1);
            if (i == 2) check("t6_cnt2", {28'b0, stall_cnt2}, 32'h1);
            if (i == 30) check("t6_cnt30", {28'b0, stall_cnt2}, 32'hF);
            if (i == 41) check("t6_cnt41", {28'b0, stall_cnt2}, 32'hF);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
